expr_stream_checker: RTL
========================

// Module: expr_stream_checker
// PURPOSE
//  Streaming syntax checker for ASCII arithmetic expressions, one char per accepted cycle.
//  Accepts multi-digit operands, binary operators '+' '*' '-', and (optionally) nested parentheses.
//  Raises out while the prefix consumed so far is a complete, well-formed expression.
//  Sits behind the character input stage; out and err feed the status/LED logic.
// PARAMETERS
//  DATA_W      8  width of character input (ASCII in bits [7:0]; upper bits must be 0, else illegal char)
//  MAX_DIGITS  4  max digits per operand (1..15); a longer run of digits is an error
//  MAX_DEPTH   4  max paren nesting (1..15); only meaningful with EXPR_PAREN_EN
//  DEPTH_W     $clog2(MAX_DEPTH+1)  width of depth output (derived, not overridden)
// PORTS
//  clk       in   1        clock, rising edge
//  clr_n     in   1        asynchronous active-low reset
//  restart   in   1        synchronous restart; priority over in_valid
//  in_valid  in   1        in carries a character this cycle
//  in        in   DATA_W   ASCII character
//  out       out  1        registered: consumed prefix is a complete valid expression
//  err       out  1        registered, sticky: syntax error detected since reset/restart
//  depth     out  DEPTH_W  registered current open-paren count
// BEHAVIOUR
//  Reset (clr_n low, async): state=EMPTY, out=0, err=0, depth=0, digit count=0. Release is sync to clk.
//  restart=1 at an edge: same values as reset on that edge, in_valid ignored that cycle.
//  in_valid=0: all registers hold. Latency: 1 cycle, outputs reflect the char accepted at the previous edge.
//  Char classes: DIGIT '0'..'9'; OP '+','*','-'; LP '('; RP ')'; anything else ILLEGAL.
//  States (out=1 only in NUM or CLOSE with depth==0 next value):
//   EMPTY : DIGIT->NUM(cnt=1); LP->EXPECT(depth+1); else ERROR
//   EXPECT: (after OP or LP) same transitions as EMPTY
//   NUM   : DIGIT->NUM(cnt+1), or ERROR if cnt==MAX_DIGITS; OP->EXPECT(cnt=0);
//           RP->CLOSE(depth-1) if depth>0, else ERROR; LP/ILLEGAL->ERROR
//   CLOSE : OP->EXPECT; RP->CLOSE(depth-1) if depth>0, else ERROR; DIGIT/LP/ILLEGAL->ERROR
//   ERROR : absorbing until reset/restart; out=0, err=1, depth holds last value
//  LP when depth==MAX_DEPTH -> ERROR (overflow; depth not incremented).
//  Entering ERROR: err<=1 and out<=0 on the same edge.
//  '-' is binary only; unary minus (leading '-' or '-' after '(' or OP) is an error.
//  Leading zeros permitted ("007" is a valid 3-digit operand).
// CONFIGURATION
//  EXPR_PAREN_EN defined: parentheses supported as above.
//  EXPR_PAREN_EN undefined: '(' and ')' classed ILLEGAL (-> ERROR), depth tied to 0,
//   CLOSE state and depth counter not synthesised; MAX_DEPTH ignored.
// STRUCTURE
//  Package expr_pkg: state enum (EMPTY, EXPECT, NUM, CLOSE, ERROR), char-class enum,
//   ASCII constants for digits/operators/parens.
//  Sub-module expr_char_class: combinational DATA_W -> char-class decoder (upper-bit check included).
//  Top: FSM, digit counter, depth counter, output registers.
// TESTING
//  "12+345*6" (MAX_DIGITS=4) -> out after each char: 1,1,0,1,1,1,0,1; err stays 0.
//  "12345" -> out 1,1,1,1 then err=1,out=0 on 5th char; later "+1" leaves err=1.
//  PAREN_EN: "(1+(2*3))" -> depth 1,1,1,2,2,2,2,1,0; out=1 only after final ')'.
//  PAREN_EN, MAX_DEPTH=2: "(((" -> err=1 on 3rd char, depth=2; ")" at depth 0 -> err.
//  "+1", "1++2", "1a" -> err=1 at the offending char; no PAREN_EN: "(1)" -> err on '('.
//  restart and in_valid both high mid-expression -> all outputs 0 next cycle, char dropped;
//   clr_n pulsed low between edges -> outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the expression stream checker.
// Parenthesis support is selected with EXPR_PAREN_EN.
package expr_pkg;

    typedef enum logic [2:0] {
        StEmpty,
        StExpect,
        StNum,
        StClose,
        StError
    } state_e;

    typedef enum logic [2:0] {
        ClsDigit,
        ClsOp,
        ClsLp,
        ClsRp,
        ClsIllegal
    } char_class_e;

    localparam logic [7:0] AsciiZero   = 8'h30;
    localparam logic [7:0] AsciiNine   = 8'h39;
    localparam logic [7:0] AsciiPlus   = 8'h2B;
    localparam logic [7:0] AsciiStar   = 8'h2A;
    localparam logic [7:0] AsciiMinus  = 8'h2D;
    localparam logic [7:0] AsciiLParen = 8'h28;
    localparam logic [7:0] AsciiRParen = 8'h29;

endpackage

// File: rtl/expr_stream_checker_if.sv
// Character stream and status bundle between the input stage and the checker.
// Widths must match the DATA_W / derived DEPTH_W of the attached checker.
interface expr_stream_checker_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH_W = 3
);
    logic               restart;
    logic               in_valid;
    logic [DATA_W-1:0]  in;
    logic               out;
    logic               err;
    logic [DEPTH_W-1:0] depth;

    modport master (
        output restart, in_valid, in,
        input  out, err, depth
    );

    modport slave (
        input  restart, in_valid, in,
        output out, err, depth
    );
endinterface

// File: rtl/expr_char_class.sv
// Combinational character-class decoder; any set bit above bit 7 makes the char illegal.
// Parens decode as LP/RP only when EXPR_PAREN_EN is defined.
module expr_char_class
    import expr_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] ch_i,
    output char_class_e       cls_o
);
    logic       upper_zero;
    logic [7:0] lo;

    assign upper_zero = ((ch_i >> 8) == '0);
    assign lo         = ch_i[7:0];

    always_comb begin
        cls_o = ClsIllegal;
        if (upper_zero) begin
            if (lo >= AsciiZero && lo <= AsciiNine) begin
                cls_o = ClsDigit;
            end else begin
                case (lo)
                    AsciiPlus, AsciiStar, AsciiMinus: cls_o = ClsOp;
`ifdef EXPR_PAREN_EN
                    AsciiLParen: cls_o = ClsLp;
                    AsciiRParen: cls_o = ClsRp;
`endif
                    default: cls_o = ClsIllegal;
                endcase
            end
        end
    end
endmodule

// File: rtl/expr_stream_checker.sv
// Streaming syntax checker for ASCII arithmetic expressions, one char per accepted cycle.
// Define EXPR_PAREN_EN to enable nested parentheses and the depth counter.
module expr_stream_checker
    import expr_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned MAX_DEPTH  = 4
) (
    input logic                   clk,
    input logic                   clr_n,
    expr_stream_checker_if.slave  bus
);
    localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int unsigned CNT_W   = $clog2(MAX_DIGITS + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_q, out_d;
    logic               err_q, err_d;
    char_class_e        cls;
`ifdef EXPR_PAREN_EN
    logic [DEPTH_W-1:0] depth_q, depth_d;
`endif

    expr_char_class #(
        .DATA_W (DATA_W)
    ) u_char_class (
        .ch_i  (bus.in),
        .cls_o (cls)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef EXPR_PAREN_EN
        depth_d = depth_q;
`endif
        if (bus.restart) begin
            state_d = StEmpty;
            cnt_d   = '0;
`ifdef EXPR_PAREN_EN
            depth_d = '0;
`endif
        end else if (bus.in_valid) begin
            case (state_q)
                StEmpty, StExpect: begin
                    if (cls == ClsDigit) begin
                        state_d = StNum;
                        cnt_d   = CNT_W'(1);
                    end
`ifdef EXPR_PAREN_EN
                    else if (cls == ClsLp && depth_q != DEPTH_W'(MAX_DEPTH)) begin
                        state_d = StExpect;
                        depth_d = depth_q + 1'b1;
                    end
`endif
                    else begin
                        state_d = StError;
                    end
                end
                StNum: begin
                    if (cls == ClsDigit) begin
                        if (cnt_q == CNT_W'(MAX_DIGITS)) state_d = StError;
                        else                             cnt_d   = cnt_q + 1'b1;
                    end else if (cls == ClsOp) begin
                        state_d = StExpect;
                        cnt_d   = '0;
                    end
`ifdef EXPR_PAREN_EN
                    else if (cls == ClsRp && depth_q != '0) begin
                        state_d = StClose;
                        cnt_d   = '0;
                        depth_d = depth_q - 1'b1;
                    end
`endif
                    else begin
                        state_d = StError;
                    end
                end
`ifdef EXPR_PAREN_EN
                StClose: begin
                    if (cls == ClsOp) begin
                        state_d = StExpect;
                    end else if (cls == ClsRp && depth_q != '0) begin
                        depth_d = depth_q - 1'b1;
                    end else begin
                        state_d = StError;
                    end
                end
`endif
                // StError is absorbing until reset or restart
                default: state_d = state_q;
            endcase
        end

        err_d = (state_d == StError);
`ifdef EXPR_PAREN_EN
        out_d = (state_d == StNum || state_d == StClose) && (depth_d == '0);
`else
        out_d = (state_d == StNum);
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= StEmpty;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

`ifdef EXPR_PAREN_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) depth_q <= '0;
        else        depth_q <= depth_d;
    end

    assign bus.depth = depth_q;
`else
    assign bus.depth = '0;
`endif

    assign bus.out = out_q;
    assign bus.err = err_q;
endmodule
